// File: rtl/pipe_stage_buffer_pkg.sv
// Shared pipeline package: stage-signal payload structs carried between core
// pipeline stages. Buffer instances set DATA_W=$bits(<struct>) and cast their
// payload to/from a flat vector at the instance boundary.
package pipe_stage_buffer_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_SLT = 3'd5,
      ALU_SLL = 3'd6,
      ALU_SRL = 3'd7
   } alu_op_e;

   // fetch -> decode
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     instr;
   } decode_stage_t;

   // decode -> execute
   typedef struct packed {
      logic [XLEN-1:0]       pc;
      logic [XLEN-1:0]       rs1_val;
      logic [XLEN-1:0]       rs2_val;
      logic [XLEN-1:0]       imm;
      logic [REG_ADDR_W-1:0] rd;
      alu_op_e               alu_op;
      logic                  use_imm;
      logic                  mem_rd;
      logic                  mem_wr;
      logic                  reg_wr;
   } execute_stage_t;

   // execute -> memory
   typedef struct packed {
      logic [XLEN-1:0]       alu_res;
      logic [XLEN-1:0]       store_val;
      logic [REG_ADDR_W-1:0] rd;
      logic                  mem_rd;
      logic                  mem_wr;
      logic                  reg_wr;
   } memory_stage_t;

   // memory -> writeback
   typedef struct packed {
      logic [XLEN-1:0]       wb_val;
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_wr;
   } writeback_stage_t;

endpackage

// File: rtl/pipe_stage_buffer_sat_counter.sv
// Saturating up-counter: counts cycles with inc=1 and sticks at all-ones.
// Ports: clk, rst_n (async active-low), inc (count this cycle),
//        value (registered count).
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] value
);

   logic [WIDTH-1:0] value_nxt;

   // hold at all-ones once reached
   always_comb begin
      value_nxt = value;
      if (inc && (value != '1)) begin
         value_nxt = value + WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
      end else begin
         value <= value_nxt;
      end
   end

endmodule

// File: rtl/pipe_stage_buffer.sv
// Elastic inter-stage register for the core pipeline. Holds up to DEPTH
// flattened stage payloads in a circular buffer under valid/ready handshakes,
// supports a same-cycle squash (flush) and counts downstream stall cycles.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush                 drop every held entry (and any push) this cycle
//   in_valid/in_ready     upstream handshake, in_data payload
//   out_valid/out_ready   downstream handshake, out_data head payload
//   count                 entries currently held
//   stall_cycles          saturating count of out_valid && !out_ready cycles
module pipe_stage_buffer
   import pipe_stage_buffer_pkg::*;
#(
   parameter  int unsigned DATA_W      = 64,
   parameter  int unsigned DEPTH       = 2,
   parameter  int unsigned READY_PASS  = 1,
   parameter  int unsigned STALL_CNT_W = 16,
   localparam int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATA_W-1:0]      in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic [CNT_W-1:0]       count,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   if ((DEPTH < 1) || (DEPTH > 4)) begin : g_depth_check
      $error("pipe_stage_buffer: DEPTH=%0d outside legal range 1..4", DEPTH);
   end

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr_nxt;
   logic [PTR_W-1:0]  wr_ptr_nxt;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_nxt;
   logic              full;
   logic              push;
   logic              pop;
   logic              stall_inc;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // when full, a same-cycle pop frees the tail slot only if READY_PASS is set
   assign full      = (count_q == FULL_CNT);
   assign in_ready  = !full || ((READY_PASS != 0) && out_ready);
   assign out_valid = (count_q != '0);
   assign out_data  = mem[rd_ptr];
   assign count     = count_q;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign stall_inc = out_valid && !out_ready;

   // pointer/occupancy update; flush overrides any push or pop
   always_comb begin
      rd_ptr_nxt = rd_ptr;
      wr_ptr_nxt = wr_ptr;
      count_nxt  = count_q;
      if (flush) begin
         rd_ptr_nxt = '0;
         wr_ptr_nxt = '0;
         count_nxt  = '0;
      end else begin
         if (push) begin
            wr_ptr_nxt = ptr_inc(wr_ptr);
         end
         if (pop) begin
            rd_ptr_nxt = ptr_inc(rd_ptr);
         end
         case ({push, pop})
            2'b10:   count_nxt = count_q + CNT_W'(1);
            2'b01:   count_nxt = count_q - CNT_W'(1);
            default: count_nxt = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         rd_ptr  <= rd_ptr_nxt;
         wr_ptr  <= wr_ptr_nxt;
         count_q <= count_nxt;
      end
   end

   // payload storage; cleared on reset so out_data idles at zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push && !flush) begin
         mem[wr_ptr] <= in_data;
      end
   end

   sat_counter #(
      .WIDTH (STALL_CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_inc),
      .value (stall_cycles)
   );

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: six instances (DEPTH 1..4 with READY_PASS=1,
// DEPTH 2 with READY_PASS=0, DEPTH 2 with a 4-bit stall counter) share the
// upstream stimulus, each with its own out_ready. Each instance has a queue
// model fed on accepted pushes and a monitor that pops and compares.
module tb_pipe_stage_buffer;

   localparam int unsigned NI     = 6;
   localparam int unsigned DATA_W = 16;

   logic              clk;
   logic              rst_n;
   logic              flush;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic [NI-1:0]     out_ready;
   logic [DATA_W-1:0] seq;

   int n_checks;
   int n_fail;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d at %0t: got %0h expected %0h", nm, idx, $time, act, exp);
      end
   endtask

   for (genvar gi = 0; gi < NI; gi++) begin : g_inst
      localparam int unsigned D    = (gi < 4) ? gi + 1 : 2;
      localparam int unsigned RP   = (gi == 4) ? 0 : 1;
      localparam int unsigned SW   = (gi == 5) ? 4 : 16;
      localparam int unsigned CW   = $clog2(D + 1);
      localparam int          SMAX = (1 << SW) - 1;

      logic              in_ready;
      logic              out_valid;
      logic [DATA_W-1:0] out_data;
      logic [CW-1:0]     count;
      logic [SW-1:0]     stall_cycles;

      logic [DATA_W-1:0] q[$];
      int                exp_stall;

      pipe_stage_buffer #(
         .DATA_W      (DATA_W),
         .DEPTH       (D),
         .READY_PASS  (RP),
         .STALL_CNT_W (SW)
      ) u_dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .flush        (flush),
         .in_valid     (in_valid),
         .in_ready     (in_ready),
         .in_data      (in_data),
         .out_valid    (out_valid),
         .out_ready    (out_ready[gi]),
         .out_data     (out_data),
         .count        (count),
         .stall_cycles (stall_cycles)
      );

      // monitor: compare what the DUT presents, then retire the upcoming handshake
      always @(negedge clk) begin : monitor
         bit exp_valid;
         bit exp_ready;
         if (!rst_n) begin
            q.delete();
            exp_stall = 0;
         end else begin
            exp_valid = (q.size() != 0);
            exp_ready = (q.size() < D) || ((RP != 0) && out_ready[gi] && (q.size() == D));
            check("count", gi, 32'(count), 32'(q.size()));
            check("out_valid", gi, 32'(out_valid), 32'(exp_valid));
            check("in_ready", gi, 32'(in_ready), 32'(exp_ready));
            check("stall_cycles", gi, 32'(stall_cycles), 32'(exp_stall));
            if (exp_valid) begin
               check("out_data", gi, 32'(out_data), 32'(q[0]));
               if (out_ready[gi]) begin
                  void'(q.pop_front());
               end else if (exp_stall < SMAX) begin
                  exp_stall++;
               end
            end
            if (flush) begin
               q.delete();
            end
         end
      end

      // stimulus side: record every accepted push as an expected output
      always @(negedge clk) begin : push_side
         #2;
         if (rst_n && !flush && in_valid && in_ready) begin
            q.push_back(in_data);
         end
      end

      // asynchronous reset must clear state without waiting for a clock edge
      always @(negedge rst_n) begin : reset_check
         #1;
         check("rst_out_valid", gi, 32'(out_valid), 32'(0));
         check("rst_count", gi, 32'(count), 32'(0));
         check("rst_stall", gi, 32'(stall_cycles), 32'(0));
         check("rst_out_data", gi, 32'(out_data), 32'(0));
         q.delete();
         exp_stall = 0;
      end
   end

   function automatic logic [NI-1:0] rand_mask(input int thr);
      logic [NI-1:0] m;
      for (int i = 0; i < NI; i++) begin
         m[i] = ($urandom_range(0, 7) < thr);
      end
      return m;
   endfunction

   task automatic drive(input logic iv, input logic fl, input logic [NI-1:0] ordy);
      @(posedge clk);
      #1;
      in_valid  = iv;
      flush     = fl;
      out_ready = ordy;
      in_data   = seq;
      seq       = seq + DATA_W'(1);
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      seq       = DATA_W'(16'h000A);
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #3 rst_n = 1'b1;

      // back-to-back streaming with downstream always ready
      repeat (10) drive(1'b1, 1'b0, '1);

      // downstream stalled: fill, hold off, then drain in order
      repeat (6) drive(1'b1, 1'b0, '0);
      repeat (8) drive(1'b0, 1'b0, '1);

      // full buffers see push and pop in the same cycle
      repeat (5) drive(1'b1, 1'b0, '0);
      drive(1'b1, 1'b0, '1);
      @(negedge clk);
      #3;
      check("full_pass_in_ready", 1, 32'(g_inst[1].in_ready), 32'(1));
      check("full_nopass_in_ready", 4, 32'(g_inst[4].in_ready), 32'(0));
      repeat (4) drive(1'b1, 1'b0, '1);

      // flush while full with a push offered in the same cycle
      repeat (5) drive(1'b1, 1'b0, '0);
      drive(1'b1, 1'b1, '0);
      drive(1'b0, 1'b0, '0);
      @(negedge clk);
      #3;
      check("flush_count", 1, 32'(g_inst[1].count), 32'(0));
      check("flush_out_valid", 1, 32'(g_inst[1].out_valid), 32'(0));

      // long stall saturates the narrow counter
      repeat (25) drive(1'b1, 1'b0, '0);
      @(negedge clk);
      #3;
      check("stall_saturate", 5, 32'(g_inst[5].stall_cycles), 32'(15));
      repeat (6) drive(1'b0, 1'b0, '1);

      // asynchronous reset between clock edges in the middle of traffic
      repeat (5) drive(1'b1, 1'b0, rand_mask(4));
      @(posedge clk);
      #3;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      flush    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #3 rst_n = 1'b1;
      repeat (3) drive(1'b1, 1'b0, '1);

      // randomized traffic with varying downstream readiness
      for (int ph = 0; ph < 4; ph++) begin
         repeat (500) begin
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0),
                  rand_mask(ph * 2 + 1));
         end
      end

      repeat (10) drive(1'b0, 1'b0, '1);
      @(negedge clk);
      #5;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
